// File: rtl/johnson_seq_ctrl_pkg.sv
// Shared definitions for the Johnson sequence controller.
//   - Parameter defaults for ring width (N) and lap-count width (LW).
//   - FSM state encoding used by johnson_seq_ctrl.
//   - johnson_pattern(): the value of ring state <idx> for an n-bit ring,
//     used to build the one-hot phase decode at elaboration time.
package johnson_seq_ctrl_pkg;

    localparam int JOHNSON_N_DEFAULT  = 4;
    localparam int JOHNSON_LW_DEFAULT = 8;
    localparam int JOHNSON_N_MAX      = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_RECOVER = 2'b10
    } seq_state_e;

    // States 0..n fill with ones from the LSB (0000, 0001, ... 1111);
    // states n+1..2n-1 drain ones from the LSB (1110, 1100, 1000).
    function automatic logic [JOHNSON_N_MAX-1:0] johnson_pattern(input int idx, input int n);
        logic [JOHNSON_N_MAX-1:0] pat;
        pat = '0;
        for (int b = 0; b < JOHNSON_N_MAX; b++) begin
            if (b < n) begin
                if (idx <= n) begin
                    pat[b] = (b < idx);
                end else begin
                    pat[b] = (b >= idx - n);
                end
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/johnson_seq_ctrl_core.sv
// johnson_core: the Johnson ring register with its next-state logic and a
// legality check.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (ring -> 0)
//   advance        step the ring to its next Johnson state
//   clear          force the ring to all-zero
//   load           force the ring to load_val (highest priority)
//   load_val [N]   value taken when load=1
//   q        [N]   current ring value
//   legal          1 when q is one of the 2N Johnson states
module johnson_core #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         advance,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] q,
    output logic         legal
);

    logic [N-1:0] ring_q;
    logic [N-1:0] ring_d;
    logic [N-2:0] edge_w;
    int           edge_cnt;

    always_comb begin
        ring_d = ring_q;
        if (load) begin
            ring_d = load_val;
        end else if (clear) begin
            ring_d = '0;
        end else if (advance) begin
            ring_d = {ring_q[N-2:0], ~ring_q[N-1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ring_q <= '0;
        end else begin
            ring_q <= ring_d;
        end
    end

    // A Johnson state has at most one 0/1 transition between adjacent bits
    // (the comparison is not circular, so 1000 and 0001 both count as one).
    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_edge
            assign edge_w[gi] = ring_q[gi] ^ ring_q[gi+1];
        end
    endgenerate

    always_comb begin
        edge_cnt = 0;
        for (int i = 0; i < N - 1; i++) begin
            edge_cnt = edge_cnt + int'(edge_w[i]);
        end
    end

    assign legal = (edge_cnt <= 1);
    assign q     = ring_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: runs a Johnson ring for a programmed number of laps.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   start              begin a run of `laps` full ring cycles (IDLE only)
//   stop               abort a run; wins over a simultaneous start
//   step               advance the ring one state while IDLE
//   laps     [LW]      laps per run, 0 = run until stop; sampled on start
//   load_en/load_val   force the ring to load_val and return to IDLE
//   err_clr            clear the sticky error flag
//   q        [N]       current ring state
//   phase    [2N]      one-hot decode of q (all-zero when q is illegal)
//   busy               high while running
//   done               one-cycle pulse when a counted run completes
//   lap_cnt  [LW]      laps completed in the current or last run
//   err                sticky: an illegal ring value was seen
module johnson_seq_ctrl
    import johnson_seq_ctrl_pkg::*;
#(
    parameter int N  = JOHNSON_N_DEFAULT,
    parameter int LW = JOHNSON_LW_DEFAULT
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           stop,
    input  logic           step,
    input  logic [LW-1:0]  laps,
    input  logic           load_en,
    input  logic [N-1:0]   load_val,
    input  logic           err_clr,
    output logic [N-1:0]   q,
    output logic [2*N-1:0] phase,
    output logic           busy,
    output logic           done,
    output logic [LW-1:0]  lap_cnt,
    output logic           err
);

    seq_state_e    state_q, state_d;
    logic [LW-1:0] lap_cnt_q, lap_cnt_d;
    logic [LW-1:0] laps_q, laps_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          core_advance;
    logic          core_clear;
    logic          core_load;
    logic [N-1:0]  q_w;
    logic          legal_w;
    logic          wrap_w;

    johnson_core #(
        .N (N)
    ) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .advance  (core_advance),
        .clear    (core_clear),
        .load     (core_load),
        .load_val (load_val),
        .q        (q_w),
        .legal    (legal_w)
    );

    // The last ring state (MSB only) advances to all-zero: that is a lap.
    assign wrap_w = q_w[N-1] & ~(|q_w[N-2:0]);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            lap_cnt_q <= '0;
            laps_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lap_cnt_q <= lap_cnt_d;
            laps_q    <= laps_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        lap_cnt_d    = lap_cnt_q;
        laps_d       = laps_q;
        done_d       = 1'b0;
        core_advance = 1'b0;
        core_clear   = 1'b0;
        core_load    = 1'b0;
        // A fresh error outranks a clear on the same edge.
        err_d        = (err_q & ~err_clr) | ~legal_w;

        if (load_en) begin
            core_load = 1'b1;
            state_d   = ST_IDLE;
        end else if (!legal_w) begin
            core_clear = 1'b1;
            state_d    = ST_RECOVER;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        core_clear = 1'b1;
                        lap_cnt_d  = '0;
                        laps_d     = laps;
                        state_d    = ST_RUN;
                    end else if (step) begin
                        core_advance = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else begin
                        core_advance = 1'b1;
                        if (wrap_w) begin
                            if ((laps_q != '0) && ((lap_cnt_q + LW'(1)) == laps_q)) begin
                                lap_cnt_d = laps_q;
                                done_d    = 1'b1;
                                state_d   = ST_IDLE;
                            end else if (lap_cnt_q != '1) begin
                                lap_cnt_d = lap_cnt_q + LW'(1);
                            end
                        end
                    end
                end
                ST_RECOVER: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == ST_RUN);
    end

    generate
        for (genvar gi = 0; gi < 2 * N; gi++) begin : g_phase
            localparam logic [JOHNSON_N_MAX-1:0] PAT = johnson_pattern(gi, N);
            assign phase[gi] = (q_w == PAT[N-1:0]);
        end
    endgenerate

    assign q       = q_w;
    assign done    = done_q;
    assign lap_cnt = lap_cnt_q;
    assign err     = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
module tb_johnson_seq_ctrl;

    localparam int N  = 4;
    localparam int LW = 8;
    localparam int NS = 2 * N;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start, stop, step, load_en, err_clr;
    logic [LW-1:0]  laps;
    logic [N-1:0]   load_val;
    logic [N-1:0]   q;
    logic [NS-1:0]  phase;
    logic           busy, done, err;
    logic [LW-1:0]  lap_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: ring value as a plain integer, mode 0=idle 1=run 2=recover
    int m_q, m_mode, m_lap, m_laps, m_done, m_err;

    always #5 clk = ~clk;

    johnson_seq_ctrl #(.N(N), .LW(LW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .step     (step),
        .laps     (laps),
        .load_en  (load_en),
        .load_val (load_val),
        .err_clr  (err_clr),
        .q        (q),
        .phase    (phase),
        .busy     (busy),
        .done     (done),
        .lap_cnt  (lap_cnt),
        .err      (err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sequence state i as a number: i low ones while filling, then ones
    // draining from the bottom.
    function automatic int seq_val(input int i);
        if (i <= N) return (1 << i) - 1;
        return ((1 << N) - 1) - ((1 << (i - N)) - 1);
    endfunction

    function automatic int seq_idx(input int v);
        for (int i = 0; i < NS; i++) begin
            if (seq_val(i) == v) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_q = 0; m_mode = 0; m_lap = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        int idx;
        int nxt;
        if (!reset_n) begin
            model_reset();
            return;
        end
        idx    = seq_idx(m_q);
        m_done = 0;
        m_err  = ((m_err != 0) && !err_clr) || (idx < 0) ? 1 : 0;
        if (load_en) begin
            m_q = int'(load_val);
            m_mode = 0;
        end else if (idx < 0) begin
            m_q = 0;
            m_mode = 2;
        end else if (m_mode == 0) begin
            if (start && !stop) begin
                m_q = 0; m_lap = 0; m_laps = int'(laps); m_mode = 1;
            end else if (step) begin
                m_q = seq_val((idx + 1) % NS);
            end
        end else if (m_mode == 1) begin
            if (stop) begin
                m_mode = 0;
            end else begin
                nxt = (idx + 1) % NS;
                m_q = seq_val(nxt);
                if (nxt == 0) begin
                    if (m_laps != 0 && m_lap + 1 == m_laps) begin
                        m_lap = m_lap + 1; m_mode = 0; m_done = 1;
                    end else if (m_lap < (1 << LW) - 1) begin
                        m_lap = m_lap + 1;
                    end
                end
            end
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic compare_all();
        int idx;
        int exp_phase;
        idx = seq_idx(m_q);
        exp_phase = (idx >= 0) ? (1 << idx) : 0;
        check_val("q",       32'(q),       32'(m_q));
        check_val("phase",   32'(phase),   32'(exp_phase));
        check_val("busy",    32'(busy),    32'(m_mode == 1));
        check_val("done",    32'(done),    32'(m_done));
        check_val("lap_cnt", 32'(lap_cnt), 32'(m_lap));
        check_val("err",     32'(err),     32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; step = 1'b0; load_en = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; idle_inputs(); laps = '0; load_val = '0; m_laps = 0;
        model_reset();
        #1;
        compare_all();
        tick(); tick();
        reset_n = 1'b1;
        tick();
        $display("txn reset: q=%b busy=%0d lap_cnt=%0d err=%0d", q, busy, lap_cnt, err);

        // Two-lap counted run: done pulses on edge 17 (start edge = edge 1)
        start = 1'b1; laps = 8'd2;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 17; k++) begin
            tick();
            if (k == 9) check_val("lap_after_wrap1", 32'(lap_cnt), 32'd1);
        end
        check_val("done_edge17", 32'(done), 32'd1);
        check_val("q_end_run", 32'(q), 32'h0);
        check_val("lap_end_run", 32'(lap_cnt), 32'd2);
        tick();
        check_val("done_one_cycle", 32'(done), 32'd0);
        $display("txn laps2_run: q=%b lap_cnt=%0d", q, lap_cnt);

        // Free run, then abort: ring holds at 1110 with one lap done
        start = 1'b1; laps = 8'd0;
        tick();
        start = 1'b0;
        repeat (13) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("stop_q", 32'(q), 32'hE);
        check_val("stop_busy", 32'(busy), 32'd0);
        check_val("stop_lap", 32'(lap_cnt), 32'd1);
        check_val("stop_no_done", 32'(done), 32'd0);
        tick();
        $display("txn stop_run: q=%b lap_cnt=%0d busy=%0d", q, lap_cnt, busy);

        // Three idle steps from zero
        load_en = 1'b1; load_val = 4'h0;
        tick();
        load_en = 1'b0; step = 1'b1;
        repeat (3) tick();
        step = 1'b0;
        check_val("step_q", 32'(q), 32'h7);
        check_val("step_phase", 32'(phase), 32'h08);
        check_val("step_lap", 32'(lap_cnt), 32'd1);
        $display("txn idle_step: q=%b phase=%b", q, phase);

        // Illegal load, recovery, error clear
        load_en = 1'b1; load_val = 4'b0101;
        tick();
        load_en = 1'b0;
        check_val("load_q", 32'(q), 32'h5);
        check_val("load_phase", 32'(phase), 32'h0);
        tick();
        check_val("recover_q", 32'(q), 32'h0);
        check_val("recover_err", 32'(err), 32'd1);
        check_val("recover_busy", 32'(busy), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_val("err_cleared", 32'(err), 32'd0);
        $display("txn illegal_load: q=%b err=%0d", q, err);

        // Start+stop together, then a start pulse while busy
        start = 1'b1; stop = 1'b1; laps = 8'd3;
        tick();
        stop = 1'b0;
        check_val("start_stop_idle", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; laps = 8'd1;
        tick();
        start = 1'b0;
        repeat (24) tick();
        $display("txn start_while_busy: q=%b lap_cnt=%0d", q, lap_cnt);

        // Asynchronous reset in the middle of a run
        start = 1'b1; laps = 8'd0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check_val("pre_reset_q", 32'(q), 32'h7);
        reset_n = 1'b0;
        #1;
        check_val("async_q", 32'(q), 32'h0);
        check_val("async_busy", 32'(busy), 32'd0);
        check_val("async_lap", 32'(lap_cnt), 32'd0);
        check_val("async_phase", 32'(phase), 32'h01);
        model_reset();
        tick(); tick();
        reset_n = 1'b1;
        tick();
        $display("txn async_reset: q=%b busy=%0d", q, busy);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset_n  = ($urandom_range(0, 299) != 0);
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            step     = ($urandom_range(0, 3) == 0);
            load_en  = ($urandom_range(0, 31) == 0);
            err_clr  = ($urandom_range(0, 7) == 0);
            laps     = LW'($urandom_range(0, 3));
            load_val = N'($urandom);
            tick();
        end
        reset_n = 1'b1; idle_inputs();
        $display("txn random: q=%b lap_cnt=%0d err=%0d", q, lap_cnt, err);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
